uart_burst_transmitter: RTL and testbench

//  Buffered, parametrised UART frame transmitter.

---
 rtl/uart_burst_transmitter.sv | 153 +++++++++++++++
 tb/tb_uart_burst_transmitter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_burst_transmitter.sv
// Buffered UART frame transmitter. Words are queued in a small FIFO and sent back-to-back
// using a frame format (bit period, parity, stop bits, idle gap) captured at each frame start.
module uart_burst_transmitter #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int PRESCALE_WIDTH = 6,
  parameter int GAP_WIDTH      = 4
) (
  input  logic                          UART_clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         data_in,
  input  logic                          data_valid,
  output logic                          data_ready,
  input  logic [PRESCALE_WIDTH-1:0]     prescale,
  input  logic                          parity_enable,
  input  logic                          parity_type,
  input  logic                          two_stop_bits,
  input  logic [GAP_WIDTH-1:0]          frame_gap,
  output logic                          serial_data_out,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  state_t                     state, state_nxt;
  logic [DATA_WIDTH-1:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]           wr_ptr, rd_ptr;
  logic                       push, pop, start_entry;

  logic [DATA_WIDTH-1:0]      shifter;
  logic                       par_bit;
  logic [PRESCALE_WIDTH-1:0]  p_lat, p_eff, bit_cnt;
  logic                       par_en_lat, two_stop_lat;
  logic [GAP_WIDTH-1:0]       gap_lat, gap_cnt;
  logic [IDX_W-1:0]           bit_idx;
  logic                       bit_end, fifo_nonempty;

  assign data_ready    = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign fifo_nonempty = (fifo_count != '0);
  assign push          = data_valid & data_ready;
  assign start_entry   = (state_nxt == START) && (state != START);
  assign pop           = start_entry;
  assign p_eff         = (prescale == '0) ? PRESCALE_WIDTH'(1) : prescale;
  assign bit_end       = (bit_cnt == '0);

  // FIFO storage and pointers; a reset flushes by clearing pointers and count
  always_ff @(posedge UART_clk) begin
    if (push) fifo_mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge UART_clk) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge UART_clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (fifo_nonempty) state_nxt = START;
      START:  if (bit_end) state_nxt = DATA;
      DATA:   if (bit_end && bit_idx == '0) state_nxt = par_en_lat ? PARITY : STOP;
      PARITY: if (bit_end) state_nxt = STOP;
      STOP: begin
        if (bit_end && bit_idx == '0) begin
          if (gap_lat != '0)      state_nxt = GAP;
          else if (fifo_nonempty) state_nxt = START;
          else                    state_nxt = IDLE;
        end
      end
      GAP:    if (gap_cnt == '0) state_nxt = fifo_nonempty ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Frame datapath: word/format capture at frame start, bit timing and bit indexing.
  // bit_idx counts data bits in DATA and the remaining extra stop bit in STOP.
  always_ff @(posedge UART_clk) begin
    if (start_entry) begin
      shifter      <= fifo_mem[rd_ptr];
      par_bit      <= (^fifo_mem[rd_ptr]) ^ parity_type;
      p_lat        <= p_eff;
      par_en_lat   <= parity_enable;
      two_stop_lat <= two_stop_bits;
      gap_lat      <= frame_gap;
      bit_cnt      <= p_eff - 1'b1;
    end else begin
      case (state)
        START: begin
          bit_cnt <= bit_end ? p_lat - 1'b1 : bit_cnt - 1'b1;
          if (bit_end) bit_idx <= IDX_W'(DATA_WIDTH - 1);
        end
        DATA: begin
          bit_cnt <= bit_end ? p_lat - 1'b1 : bit_cnt - 1'b1;
          if (bit_end) begin
            if (bit_idx != '0) begin
              shifter <= shifter >> 1;
              bit_idx <= bit_idx - 1'b1;
            end else begin
              bit_idx <= two_stop_lat ? IDX_W'(1) : IDX_W'(0);
            end
          end
        end
        PARITY: bit_cnt <= bit_end ? p_lat - 1'b1 : bit_cnt - 1'b1;
        STOP: begin
          bit_cnt <= bit_end ? p_lat - 1'b1 : bit_cnt - 1'b1;
          if (bit_end && bit_idx != '0) bit_idx <= bit_idx - 1'b1;
          if (bit_end && bit_idx == '0) gap_cnt <= gap_lat - 1'b1;
        end
        GAP:     gap_cnt <= gap_cnt - 1'b1;
        default: bit_cnt <= bit_cnt;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    serial_data_out = 1'b1;
    busy            = (state != IDLE);
    frame_done      = 1'b0;
    case (state)
      START:   serial_data_out = 1'b0;
      DATA:    serial_data_out = shifter[0];
      PARITY:  serial_data_out = par_bit;
      STOP:    frame_done      = bit_end && (bit_idx == '0);
      default: serial_data_out = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_burst_transmitter.sv
// Bench for uart_burst_transmitter: directed frame scenarios plus randomized traffic, compared
// every cycle against a waveform-level reference model built from the frame format rules.
module tb_uart_burst_transmitter;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic           UART_clk = 1'b0;
  logic           reset;
  logic [DW-1:0]  data_in;
  logic           data_valid;
  logic           data_ready;
  logic [5:0]     prescale;
  logic           parity_enable, parity_type, two_stop_bits;
  logic [3:0]     frame_gap;
  logic           serial_data_out, busy, frame_done;
  logic [2:0]     fifo_count;

  uart_burst_transmitter #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PRESCALE_WIDTH(6), .GAP_WIDTH(4)
  ) dut (
    .UART_clk(UART_clk), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .prescale(prescale), .parity_enable(parity_enable),
    .parity_type(parity_type), .two_stop_bits(two_stop_bits), .frame_gap(frame_gap),
    .serial_data_out(serial_data_out), .busy(busy), .frame_done(frame_done),
    .fifo_count(fifo_count)
  );

  always #5 UART_clk = ~UART_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queued words plus the expected per-cycle line waveform of the
  // frame in flight; each entry is {frame_done, line}.
  logic [DW-1:0] mfifo [$];
  logic [1:0]    wave [$];
  bit            chk_en = 0;

  task automatic build_frame(input logic [DW-1:0] w);
    int   p;
    logic bits [$];
    logic [1:0] e;
    p = (prescale == 0) ? 1 : int'(prescale);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
    if (parity_enable) bits.push_back((^w) ^ parity_type);
    bits.push_back(1'b1);
    if (two_stop_bits) bits.push_back(1'b1);
    foreach (bits[i]) repeat (p) wave.push_back({1'b0, bits[i]});
    e = wave.pop_back();
    e[1] = 1'b1;
    wave.push_back(e);
    repeat (int'(frame_gap)) wave.push_back(2'b01);
  endtask

  task automatic model_step();
    int pre;
    bit push_ok;
    if (!reset) begin
      mfifo.delete();
      wave.delete();
      chk_en = 1;
    end else begin
      pre     = mfifo.size();
      push_ok = data_valid && (pre != DEPTH);
      if (wave.size() != 0) void'(wave.pop_front());
      if (wave.size() == 0 && pre != 0) build_frame(mfifo.pop_front());
      if (push_ok) mfifo.push_back(data_in);
    end
  endtask

  // Monitors for the directed scenarios
  int   busy_cycles = 0, done_cnt = 0, busy_falls = 0;
  bit   prev_busy = 0;
  logic line_log [$];

  always @(posedge UART_clk) begin
    model_step();
    #1;
    if (chk_en) begin
      chk("line",       serial_data_out, (wave.size() != 0) ? wave[0][0] : 1'b1);
      chk("busy",       busy,            wave.size() != 0);
      chk("frame_done", frame_done,      (wave.size() != 0) ? wave[0][1] : 1'b0);
      chk("fifo_count", fifo_count,      mfifo.size());
      chk("data_ready", data_ready,      mfifo.size() != DEPTH);
    end
    if (busy) begin
      busy_cycles++;
      line_log.push_back(serial_data_out);
    end
    if (prev_busy && !busy) busy_falls++;
    if (frame_done) done_cnt++;
    prev_busy = busy;
  end

  task automatic clear_mon();
    busy_cycles = 0;
    done_cnt    = 0;
    busy_falls  = 0;
    line_log.delete();
  endtask

  task automatic set_cfg(input int p, input bit pe, input bit pt, input bit ts, input int g);
    prescale      = 6'(p);
    parity_enable = pe;
    parity_type   = pt;
    two_stop_bits = ts;
    frame_gap     = 4'(g);
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting rising edge.
  task automatic push(input logic [DW-1:0] w);
    int guard = 0;
    data_in    = w;
    data_valid = 1'b1;
    while (!data_ready && guard < 500) begin
      @(negedge UART_clk);
      guard++;
    end
    if (guard >= 500) chk("push_timeout", 1, 0);
    @(negedge UART_clk);
    data_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((busy || fifo_count != 0) && guard < 3000) begin
      @(negedge UART_clk);
      guard++;
    end
    if (guard >= 3000) chk("idle_timeout", 1, 0);
  endtask

  task automatic single_frame(input logic [DW-1:0] w, input int exp_len, input int par_idx,
                              input logic exp_par, input string tag);
    @(negedge UART_clk);
    clear_mon();
    push(w);
    wait_idle();
    chk({tag, "_busy_len"}, busy_cycles, exp_len);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    if (par_idx >= 0) chk({tag, "_parity"}, line_log[par_idx], exp_par);
  endtask

  int idx;

  initial begin
    reset = 1'b0;
    data_valid = 1'b0;
    data_in = '0;
    set_cfg(4, 1, 0, 0, 0);
    repeat (2) @(negedge UART_clk);
    chk("rst_line", serial_data_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_ready", data_ready, 1);
    reset = 1'b1;

    // Basic frame with even parity, then odd parity, then a word with odd popcount
    set_cfg(4, 1, 0, 0, 0);
    single_frame(8'hA5, 44, 36, 1'b0, "t1");
    set_cfg(4, 1, 1, 0, 0);
    single_frame(8'hA5, 44, 36, 1'b1, "t2a");
    set_cfg(4, 1, 0, 0, 0);
    single_frame(8'h07, 44, 36, 1'b1, "t2b");

    // Six words back to back through a four-deep FIFO
    set_cfg(1, 0, 0, 0, 0);
    @(negedge UART_clk);
    clear_mon();
    for (int k = 1; k <= 6; k++) push(8'(k));
    wait_idle();
    chk("t3_frames", done_cnt, 6);
    chk("t3_busy_len", busy_cycles, 60);
    chk("t3_busy_falls", busy_falls, 1);

    // Two stop bits and a gap: idle-high run between last data bit and next start bit
    set_cfg(4, 0, 0, 1, 3);
    @(negedge UART_clk);
    clear_mon();
    push(8'h3C);
    push(8'h81);
    wait_idle();
    idx = 36;
    while (idx < line_log.size() && line_log[idx] == 1'b1) idx++;
    chk("t4_high_run", idx - 36, 11);
    chk("t4_frames", done_cnt, 2);

    // Prescale of zero behaves as one cycle per bit
    set_cfg(0, 0, 0, 0, 0);
    single_frame(8'hFF, 10, -1, 1'b0, "t5");

    // Reset during data bit 3 with two words still queued
    set_cfg(4, 1, 0, 0, 2);
    @(negedge UART_clk);
    clear_mon();
    push(8'h11);
    push(8'h22);
    push(8'h33);
    idx = 0;
    while (line_log.size() < 17 && idx < 500) begin
      @(negedge UART_clk);
      idx++;
    end
    chk("t6_reached_bit3", line_log.size(), 17);
    chk("t6_queued", fifo_count, 2);
    reset = 1'b0;
    @(negedge UART_clk);
    chk("t6_line", serial_data_out, 1);
    chk("t6_busy", busy, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_done", done_cnt, 0);
    reset = 1'b1;
    set_cfg(2, 1, 1, 0, 0);
    single_frame(8'h5A, 22, 18, 1'b1, "t6_fresh");

    // Randomized traffic with format changes at arbitrary times and rare resets
    for (int c = 0; c < 1500; c++) begin
      @(negedge UART_clk);
      data_valid = ($urandom_range(0, 2) == 0);
      data_in    = 8'($urandom);
      if ($urandom_range(0, 29) == 0)
        set_cfg($urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom),
                $urandom_range(0, 3));
      reset = ($urandom_range(0, 299) != 0);
    end
    @(negedge UART_clk);
    data_valid = 1'b0;
    reset = 1'b1;
    wait_idle();
    repeat (2) @(negedge UART_clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
